// File: rtl/wb8_pkg.sv
// ============================================================================
// wb8_pkg: shared bus widths, FSM encoding and helpers for the wb8 interconnect
// Rev 1.0
// ============================================================================
`default_nettype none

package wb8_pkg;

  localparam int ADR_W = 32;
  localparam int DAT_W = 8;
  localparam logic [DAT_W-1:0] ERR_DAT_DEFAULT = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  // A one-slave fabric still needs a 1-bit select signal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb8_interconnect_if.sv
// ============================================================================
// wb8_interconnect_if: master-side and slave-side bus bundle of the interconnect
// Rev 1.0
// ============================================================================
`default_nettype none

interface wb8_interconnect_if #(
  parameter int NSLAVES = 8
);
  import wb8_pkg::*;

  logic [ADR_W-1:0]         I_wb_adr;
  logic                     I_wb_stb;
  logic [DAT_W-1:0]         O_wb_dat;
  logic                     O_wb_ack;
  logic                     O_wb_stall;
  logic [NSLAVES-1:0]       O_stb;
  logic [DAT_W*NSLAVES-1:0] I_dat;
  logic [NSLAVES-1:0]       I_ack;
  logic [NSLAVES-1:0]       I_stall;

  // Interconnect view: slave of the CPU master, driver of the slave strobes.
  modport slave (
    input  I_wb_adr, I_wb_stb, I_dat, I_ack, I_stall,
    output O_wb_dat, O_wb_ack, O_wb_stall, O_stb
  );

  // Environment view: CPU master plus the attached slave devices.
  modport master (
    output I_wb_adr, I_wb_stb, I_dat, I_ack, I_stall,
    input  O_wb_dat, O_wb_ack, O_wb_stall, O_stb
  );

endinterface

`default_nettype wire

// File: rtl/wb8_addr_decode.sv
// ============================================================================
// wb8_addr_decode: combinational base/mask window decode, lowest index wins
// Rev 1.0
// ============================================================================
`default_nettype none

module wb8_addr_decode
  import wb8_pkg::*;
#(
  parameter int                       NSLAVES    = 8,
  parameter int                       IDXW       = 3,
  parameter logic [NSLAVES*ADR_W-1:0] SLAVE_BASE = '0,
  parameter logic [NSLAVES*ADR_W-1:0] SLAVE_MASK = '0
) (
  input  wire logic [ADR_W-1:0] adr,
  output logic      [IDXW-1:0]  idx,
  output logic                  hit
);

  logic [NSLAVES-1:0] w_match;

  for (genvar i = 0; i < NSLAVES; i++) begin : g_match
    assign w_match[i] = ((adr & SLAVE_MASK[i*ADR_W +: ADR_W]) ==
                         (SLAVE_BASE[i*ADR_W +: ADR_W] & SLAVE_MASK[i*ADR_W +: ADR_W]));
  end

  // Scan from the top so the lowest matching index is the last one written.
  always_comb begin
    idx = '0;
    hit = |w_match;
    for (int i = NSLAVES - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        idx = IDXW'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb8_interconnect.sv
// ============================================================================
// wb8_interconnect: 1-to-N 8-bit bus switch with timeout bus error and fault log
// Rev 1.0
// ============================================================================
`default_nettype none

module wb8_interconnect
  import wb8_pkg::*;
#(
  parameter int                       NSLAVES        = 8,
  parameter logic [NSLAVES*ADR_W-1:0] SLAVE_BASE     = '0,
  parameter logic [NSLAVES*ADR_W-1:0] SLAVE_MASK     = '0,
  parameter int                       DEFAULT_SLAVE  = NSLAVES - 1,
  parameter int                       TIMEOUT_CYCLES = 255,
  parameter logic [DAT_W-1:0]         ERR_DAT        = ERR_DAT_DEFAULT
) (
  input  wire logic              I_wb_clk,
  input  wire logic              I_reset,
  wb8_interconnect_if.slave      bus,
  output logic                   O_fault_valid,
  output logic [ADR_W-1:0]       O_fault_adr,
  output logic [7:0]             O_fault_count,
  input  wire logic              I_fault_clear
);

  localparam int               IDXW     = idx_width(NSLAVES);
  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_fault_valid;
  logic [ADR_W-1:0]   r_fault_adr;
  logic [7:0]         r_fault_count;

  logic [IDXW-1:0]    w_dec_idx;
  logic               w_dec_hit;
  logic [IDXW-1:0]    w_sel;
  logic [NSLAVES-1:0] w_sel_onehot;
  logic [DAT_W-1:0]   w_sel_dat;
  logic               w_sel_ack;
  logic               w_sel_stall;
  logic               w_in_err;
  logic               w_timeout;

  wb8_addr_decode #(
    .NSLAVES    (NSLAVES),
    .IDXW       (IDXW),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_decode (
    .adr (bus.I_wb_adr),
    .idx (w_dec_idx),
    .hit (w_dec_hit)
  );

  assign w_sel = w_dec_hit ? w_dec_idx : IDXW'(DEFAULT_SLAVE);

  always_comb begin
    w_sel_onehot = '0;
    w_sel_dat    = '0;
    w_sel_ack    = 1'b0;
    w_sel_stall  = 1'b0;
    for (int i = 0; i < NSLAVES; i++) begin
      if (w_sel == IDXW'(i)) begin
        w_sel_onehot[i] = 1'b1;
        w_sel_dat       = bus.I_dat[i*DAT_W +: DAT_W];
        w_sel_ack       = bus.I_ack[i];
        w_sel_stall     = bus.I_stall[i];
      end
    end
  end

  assign w_in_err  = (r_state == ST_ERR);
  assign w_timeout = (r_state == ST_WAIT) && bus.I_wb_stb && !w_sel_ack && (r_cnt == CNT_LAST);

  // Slave responses pass straight through; reset gates the handshake combinationally.
  assign bus.O_stb      = (!I_reset && !w_in_err && bus.I_wb_stb) ? w_sel_onehot : '0;
  assign bus.O_wb_ack   = !I_reset && (w_in_err || w_sel_ack);
  assign bus.O_wb_dat   = w_in_err ? ERR_DAT : w_sel_dat;
  assign bus.O_wb_stall = !w_in_err && w_sel_stall;

  always_ff @(posedge I_wb_clk) begin
    if (I_reset) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_fault_valid <= 1'b0;
      r_fault_adr   <= '0;
      r_fault_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (bus.I_wb_stb && !w_sel_ack) begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!bus.I_wb_stb || w_sel_ack) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= ST_ERR;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_ERR: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase

      // A timeout landing together with a clear starts a fresh fault log.
      if (w_timeout) begin
        if (!r_fault_valid || I_fault_clear) begin
          r_fault_adr <= bus.I_wb_adr;
        end
        r_fault_valid <= 1'b1;
        if (I_fault_clear) begin
          r_fault_count <= 8'd1;
        end else if (r_fault_count != 8'hFF) begin
          r_fault_count <= r_fault_count + 8'd1;
        end
      end else if (I_fault_clear) begin
        r_fault_valid <= 1'b0;
        r_fault_count <= '0;
      end
    end
  end

  assign O_fault_valid = r_fault_valid;
  assign O_fault_adr   = r_fault_adr;
  assign O_fault_count = r_fault_count;

endmodule

`default_nettype wire

// File: tb/tb_wb8_interconnect.sv
// ============================================================================
// tb_wb8_interconnect: randomized scoreboard bench for the wb8 interconnect
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_wb8_interconnect;
  import wb8_pkg::*;

  localparam int NS = 4;
  localparam int TO = 8;
  // Slave 0 covers FFFFxxxx with address bit 8 clear (so it overlaps slave 2 at FFFFFE00).
  localparam logic [NS*32-1:0] BASE = {32'hFFFFFFFF, 32'hFFFFFC00, 32'hFFFFF900, 32'hFFFF0000};
  localparam logic [NS*32-1:0] MASK = {32'hFFFFFFFF, 32'hFFFFFC00, 32'hFFFFFF00, 32'hFFFF0100};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fault_clear = 1'b0;
  logic        fault_valid;
  logic [31:0] fault_adr;
  logic [7:0]  fault_count;

  wb8_interconnect_if #(.NSLAVES(NS)) bus();

  wb8_interconnect #(
    .NSLAVES        (NS),
    .SLAVE_BASE     (BASE),
    .SLAVE_MASK     (MASK),
    .DEFAULT_SLAVE  (3),
    .TIMEOUT_CYCLES (TO),
    .ERR_DAT        (8'hFF)
  ) dut (
    .I_wb_clk      (clk),
    .I_reset       (rst),
    .bus           (bus),
    .O_fault_valid (fault_valid),
    .O_fault_adr   (fault_adr),
    .O_fault_count (fault_count),
    .I_fault_clear (fault_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         slave;
    bit         is_err;
    int         ack_cycle;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         vectors = 0;
  int         miscompares = 0;
  int         mk = 0;
  bit         mon_en = 1'b0;
  bit         mon_in_err;
  logic [3:0] mon_exp_stb;
  bit         m_valid = 1'b0;
  logic [31:0] m_adr = '0;
  int         m_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Address map expressed as plain field tests rather than base/mask pairs.
  function automatic int model_sel(input logic [31:0] a);
    if (a[31:16] == 16'hFFFF && !a[8]) return 0;
    if (a[31:8] == 24'hFFFFF9)         return 1;
    if (a[31:10] == 22'h3FFFFF)        return 2;
    return 3;
  endfunction

  // Monitor: checks every strobe cycle against the head of the scoreboard.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (bus.I_wb_stb) begin
        if (exp_q.size() == 0) begin
          chk("strobe_without_txn", 32'd1, 32'd0);
        end else begin
          mon_e       = exp_q[0];
          mon_in_err  = mon_e.is_err && (mk == TO);
          mon_exp_stb = mon_in_err ? 4'b0000 : (4'b0001 << mon_e.slave);
          chk("o_stb", 32'(bus.O_stb), 32'(mon_exp_stb));
          chk("wb_ack", 32'(bus.O_wb_ack), 32'(mk == mon_e.ack_cycle));
          chk("wb_stall", 32'(bus.O_wb_stall),
              mon_in_err ? 32'd0 : 32'(bus.I_stall[mon_e.slave]));
          if (bus.O_wb_ack) begin
            chk("wb_dat", 32'(bus.O_wb_dat), 32'(mon_e.data));
            void'(exp_q.pop_front());
            mk = 0;
          end else begin
            mk++;
          end
        end
      end else begin
        chk("idle_ack", 32'(bus.O_wb_ack), 32'd0);
        chk("idle_stb", 32'(bus.O_stb), 32'd0);
        mk = 0;
      end
    end
  end

  task automatic check_faults();
    chk("fault_valid", 32'(fault_valid), 32'(m_valid));
    chk("fault_count", 32'(fault_count), 32'(m_count));
    if (m_valid) chk("fault_adr", fault_adr, m_adr);
  endtask

  // One read: lat = strobe cycle index at which the addressed slave acks.
  task automatic run_txn(input logic [31:0] adr, input int lat, input int clr_at);
    int         tgt  = model_sel(adr);
    bit         err  = (lat >= TO);
    int         last = err ? TO : lat;
    logic [7:0] d    = 8'($urandom);
    logic [3:0] noise;
    bit         done = 1'b0;
    int         k    = 0;
    exp_t       e;
    e.slave     = tgt;
    e.is_err    = err;
    e.ack_cycle = last;
    e.data      = err ? 8'hFF : d;
    exp_q.push_back(e);
    @(posedge clk); #1;
    bus.I_wb_adr = adr;
    bus.I_wb_stb = 1'b1;
    while (!done && k <= last + 4) begin
      bus.I_dat = $urandom;
      bus.I_dat[tgt*8 +: 8] = d;
      bus.I_stall = 4'($urandom);
      noise = 4'($urandom) & ~(4'b0001 << tgt);
      bus.I_ack = noise | ((k == lat) ? (4'b0001 << tgt) : 4'b0000);
      fault_clear = (k == clr_at);
      @(negedge clk);
      done = bus.O_wb_ack;
      @(posedge clk); #1;
      k++;
    end
    bus.I_wb_stb = 1'b0;
    bus.I_ack    = '0;
    fault_clear  = 1'b0;
    if (!done) begin
      chk("ack_within_bound", 32'd0, 32'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    for (int c = 0; c <= last; c++) begin
      if (err && c == TO - 1) begin
        if (!m_valid || c == clr_at) m_adr = adr;
        m_valid = 1'b1;
        m_count = (c == clr_at) ? 1 : ((m_count < 255) ? m_count + 1 : 255);
      end else if (c == clr_at) begin
        m_valid = 1'b0;
        m_count = 0;
      end
    end
    check_faults();
  endtask

  task automatic idle_gap(input int n, input bit clr);
    for (int i = 0; i < n; i++) begin
      fault_clear = clr && (i == 0);
      @(posedge clk); #1;
    end
    fault_clear = 1'b0;
    if (clr && n > 0) begin
      m_valid = 1'b0;
      m_count = 0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int          r;
    int          lat;
    int          clr_at;
    bus.I_wb_adr = '0;
    bus.I_wb_stb = 1'b0;
    bus.I_dat    = '0;
    bus.I_ack    = '0;
    bus.I_stall  = '0;
    repeat (2) @(posedge clk);
    #1;
    // Strobe and slave acks present during reset must not leak through.
    bus.I_wb_adr = 32'hFFFFF904;
    bus.I_wb_stb = 1'b1;
    bus.I_ack    = '1;
    @(negedge clk);
    chk("reset_stb", 32'(bus.O_stb), 32'd0);
    chk("reset_ack", 32'(bus.O_wb_ack), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.I_wb_stb = 1'b0;
    bus.I_ack    = '0;
    @(negedge clk);
    chk("post_reset_fault_valid", 32'(fault_valid), 32'd0);
    chk("post_reset_fault_adr", fault_adr, 32'd0);
    chk("post_reset_fault_count", 32'(fault_count), 32'd0);
    mon_en = 1'b1;

    run_txn(32'hFFFFF904, 2, -1);
    run_txn(32'hFFFFFE00, 1, -1);
    run_txn(32'hFFFFFD10, 0, -1);
    run_txn(32'h12345678, 3, -1);
    run_txn(32'hFFFFF800, 1000, -1);
    run_txn(32'hFFFFF900, 1000, -1);
    run_txn(32'hFFFFF805, 7, -1);
    run_txn(32'hFFFFF806, 8, -1);
    repeat (300) run_txn(32'hFFFFFD00, 1000, -1);
    run_txn(32'hFFFFF9AA, 1000, TO - 1);

    // Reset while the access sits in its third wait cycle.
    mon_en = 1'b0;
    @(posedge clk); #1;
    bus.I_wb_adr = 32'hFFFFF800;
    bus.I_wb_stb = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.I_ack = 4'b0001;
    @(negedge clk);
    chk("mid_reset_stb", 32'(bus.O_stb), 32'd0);
    chk("mid_reset_ack", 32'(bus.O_wb_ack), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.I_wb_stb = 1'b0;
    bus.I_ack    = '0;
    @(negedge clk);
    chk("abort_stb", 32'(bus.O_stb), 32'd0);
    chk("abort_ack", 32'(bus.O_wb_ack), 32'd0);
    chk("abort_fault_valid", 32'(fault_valid), 32'd0);
    chk("abort_fault_adr", fault_adr, 32'd0);
    chk("abort_fault_count", 32'(fault_count), 32'd0);
    m_valid = 1'b0;
    m_adr   = '0;
    m_count = 0;
    mk      = 0;
    mon_en  = 1'b1;
    run_txn(32'hFFFFF904, 7, -1);

    for (int n = 0; n < 200; n++) begin
      a = ($urandom_range(0, 1) == 0) ? {16'hFFFF, 16'($urandom)} : 32'($urandom);
      r = $urandom_range(0, 9);
      if (r < 7)      lat = $urandom_range(0, 7);
      else if (r < 9) lat = $urandom_range(8, 10);
      else            lat = 1000;
      clr_at = ($urandom_range(0, 5) == 0) ? $urandom_range(0, (lat >= TO) ? TO : lat) : -1;
      run_txn(a, lat, clr_at);
      if ($urandom_range(0, 3) == 0) idle_gap($urandom_range(1, 3), $urandom_range(0, 4) == 0);
    end

    if (exp_q.size() != 0) chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
